// File: rtl/id_stage.sv
// id_stage: unpacks the IF pipeline bundle, applies its write-back to a 32x32
// register file, decodes RV32I fields and registers them into the ID/EX
// boundary. A load in EX whose destination is a source of the instruction in
// ID raises a stall and inserts a bubble. A flush from EX kills the
// instruction in ID.
//
// Handshake: in_valid qualifies the instruction fields of if_in. When stall=1
// the bundle is not consumed and must be re-presented unchanged next cycle.
// ex_valid qualifies ex_*. During a bubble only ex_valid and ex_mem_read are
// meaningful.
module id_stage #(
  parameter int          XLEN      = 32,
  parameter int          BUNDLE_W  = 134,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUNDLE_W-1:0] if_in,
  input  logic                in_valid,
  input  logic                flush,
  output logic                stall,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_pc_4,
  output logic [XLEN-1:0]     ex_rs1_data,
  output logic [XLEN-1:0]     ex_rs2_data,
  output logic [XLEN-1:0]     ex_imm,
  output logic [4:0]          ex_rd,
  output logic [4:0]          ex_rs1,
  output logic [4:0]          ex_rs2,
  output logic [6:0]          ex_opcode,
  output logic [2:0]          ex_funct3,
  output logic [6:0]          ex_funct7,
  output logic                ex_mem_read
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Bundle fields
  logic [XLEN-1:0] wb_data, pc, pc_4;
  logic [31:0]     instr;
  logic [4:0]      wb_addr;
  logic            wb_en;

  assign wb_data = if_in[XLEN-1:0];
  assign wb_addr = if_in[XLEN+4:XLEN];
  assign wb_en   = if_in[XLEN+5];
  assign instr   = if_in[XLEN+37:XLEN+6];
  assign pc_4    = if_in[2*XLEN+37:XLEN+38];
  assign pc      = if_in[3*XLEN+37:2*XLEN+38];

  // Decoded fields
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic       wb_fire;

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign funct7  = instr[31:25];
  assign wb_fire = wb_en && (wb_addr != 5'd0);

  // Register file; entry 0 is never written so x0 stays 0
  logic [XLEN-1:0] rf_q [32];

  // Register file write port, honoured independently of in_valid/stall/flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_fire) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Operand read with same-cycle write-back bypass
  logic [XLEN-1:0] rs1_data, rs2_data;
  always_comb begin
    rs1_data = rf_q[rs1];
    rs2_data = rf_q[rs2];
    if (rs1 == 5'd0)                         rs1_data = '0;
    else if (wb_fire && (wb_addr == rs1))    rs1_data = wb_data;
    if (rs2 == 5'd0)                         rs2_data = '0;
    else if (wb_fire && (wb_addr == rs2))    rs2_data = wb_data;
  end

  // Immediate generation and register-use flags by opcode
  logic [XLEN-1:0] imm;
  logic            is_nop, rs1_used, rs2_used;
  always_comb begin
    imm      = '0;
    is_nop   = (instr == NOP_INSTR);
    rs1_used = !is_nop;
    rs2_used = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE: begin
        imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        rs2_used = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm      = {instr[31:12], 12'b0};
        rs1_used = 1'b0;
      end
      OP_JAL: begin
        imm      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        rs1_used = 1'b0;
      end
      OP_R:    rs2_used = 1'b1;
      default: imm = '0;
    endcase
  end

  // Load-use hazard against the load sitting in EX; flush overrides it
  logic ex_valid_q, ex_mem_read_q, hazard, issue;
  logic [4:0] ex_rd_q;
  assign hazard = in_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
                  ((rs1_used && (ex_rd_q == rs1)) || (rs2_used && (ex_rd_q == rs2)));
  assign stall  = hazard && !flush;
  assign issue  = !flush && !hazard && in_valid && !is_nop;

  logic [XLEN-1:0] ex_pc_q, ex_pc_4_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
  logic [4:0]      ex_rs1_q, ex_rs2_q;
  logic [6:0]      ex_opcode_q, ex_funct7_q;
  logic [2:0]      ex_funct3_q;

  // ID/EX register: valid/mem_read follow issue, payload loads only on issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_mem_read_q <= 1'b0;
      ex_pc_q       <= '0;
      ex_pc_4_q     <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rd_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_opcode_q   <= '0;
      ex_funct3_q   <= '0;
      ex_funct7_q   <= '0;
    end else begin
      ex_valid_q    <= issue;
      ex_mem_read_q <= issue && (opcode == OP_LOAD);
      if (issue) begin
        ex_pc_q       <= pc;
        ex_pc_4_q     <= pc_4;
        ex_rs1_data_q <= rs1_data;
        ex_rs2_data_q <= rs2_data;
        ex_imm_q      <= imm;
        ex_rd_q       <= rd;
        ex_rs1_q      <= rs1;
        ex_rs2_q      <= rs2;
        ex_opcode_q   <= opcode;
        ex_funct3_q   <= funct3;
        ex_funct7_q   <= funct7;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_mem_read = ex_mem_read_q;
  assign ex_pc       = ex_pc_q;
  assign ex_pc_4     = ex_pc_4_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_opcode   = ex_opcode_q;
  assign ex_funct3   = ex_funct3_q;
  assign ex_funct7   = ex_funct7_q;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Consumer end of the 134-bit IF pipeline-register bundle.
- Unpacks the bundle and applies its write-back fields to an internal 32x32 register file.
- Decodes the RV32I instruction and registers the operands into the ID/EX boundary.
- Detects load-use hazards, raising a stall toward fetch and inserting bubbles; accepts a flush from EX on taken branches/jumps.

Parameters:
- XLEN, 32, datapath width.
- BUNDLE_W, 134, IF bundle width = 3*XLEN + 1 + 5 + XLEN.
- NOP_INSTR, 32'h00000013, instruction value treated as a bubble (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- if_in  input  134  IF bundle {[133:102] pc, [101:70] pc_4, [69:38] instr, [37] wb_en, [36:32] wb_addr, [31:0] wb_data}.
- in_valid  input  1  if_in instruction fields are valid this cycle.
- flush  input  1  EX redirect; kill the instruction currently in ID.
- stall  output  1  combinational; fetch and IF register must hold.
- ex_valid  output  1  ID/EX entry valid.
- ex_pc, ex_pc_4  output  32 each  registered pc fields.
- ex_rs1_data, ex_rs2_data  output  32 each  operand values.
- ex_imm  output  32  sign-extended immediate.
- ex_rd, ex_rs1, ex_rs2  output  5 each  register indices.
- ex_opcode  output  7  opcode.
- ex_funct3  output  3  funct3.
- ex_funct7  output  7  funct7.
- ex_mem_read  output  1  entry is a load (opcode 0000011).

Behaviour:
- Reset (async): all ex_* outputs are 0 and ex_valid=0. Register file contents are 0 after reset.
- Register file:
  - Written on the rising edge when wb_en=1 and wb_addr!=0. Write-back fields are honoured regardless of in_valid, stall or flush.
  - x0 always reads 0; a write to x0 is ignored.
- Read bypass: if wb_en=1, wb_addr!=0 and wb_addr equals rs1 (or rs2), the operand is wb_data from the same cycle.
- Immediate select by opcode:
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011, bit0=0
  - U: 0110111, 0010111; imm = instr[31:12]<<12
  - J: 1101111, bit0=0
  - Other opcodes: imm=0.
- Register-use flags:
  - rs1 used for every opcode except U, J and NOP.
  - rs2 used for R (0110011), S and B.
- Hazard: stall = in_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((rs1 used & ex_rd==rs1) | (rs2 used & ex_rd==rs2)).
- Latency: 1 cycle from if_in to ex_*. Next-state priority, highest first:
  1. flush=1: ex_valid<=0 and ex_mem_read<=0; stall output is forced to 0.
  2. stall=1: bubble (ex_valid<=0, ex_mem_read<=0). The bundle is held upstream and re-presented next cycle; the hazard then clears.
  3. in_valid=0 or instr==NOP_INSTR: bubble.
  4. Otherwise: load all ex_* fields and set ex_valid<=1.
- During a bubble, ex_pc, ex_pc_4, ex_imm and data fields may hold stale values; only ex_valid and ex_mem_read are defined.
- Reset asserted mid-operation clears state immediately, with no clock required.

Test Plan:
- Reset: assert reset with no clock → all ex_* outputs 0, stall=0. Release reset; read x5 → 0.
- Write-back + bypass: wb_en=1, wb_addr=5, wb_data=32'hDEADBEEF, with instr add x6,x5,x0 in the same cycle → next cycle ex_rs1_data=DEADBEEF, ex_rs2_data=0, ex_valid=1.
- x0 protection: wb_en=1, wb_addr=0, wb_data=32'h1234; then read x0 → 0.
- Load-use: lw x7,0(x1) followed by add x8,x7,x2 →
  - stall=1 for exactly one cycle; ex_valid=0 in the following cycle.
  - The re-presented add then issues with ex_rs1=7 and ex_valid=1.
  - Repeating with add x8,x0,x2 gives stall=0.
- Flush priority: same load-use pair with flush=1 in the stall cycle → stall=0 and ex_valid=0 next cycle.
- Immediates:
  - instr 32'hFFF00093 (addi x1,x0,-1) → ex_imm=FFFFFFFF.
  - beq with imm=-4 (32'hFE000EE3) → ex_imm=FFFFFFFC.
  - lui 32'h123450B7 → ex_imm=12345000.
